// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

  localparam int          ADDR_W_DEF  = 10;
  localparam logic [31:0] IM_BASE_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP         = 32'h0000_0000;
  localparam int          ENTRY_W     = 65;

  // Fetch controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  // One buffered fetch result, as seen by decode.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } entry_t;

endpackage

// File: rtl/fetch_if.sv
// Bus bundle between the fetch stage, the PC unit, instruction memory and decode.
//
// Handshakes:
//   memory  : ImReq/ImAddr are held stable until ImAck. A beat completes in the
//             cycle where ImReq=1 and ImAck=1, and ImData is valid in that cycle.
//             ImAck while ImReq=0 means nothing.
//   decode  : IrValid/Instr/IrPC/IrErr describe the head entry. It is consumed
//             at the edge where IrValid=1 and IrReady=1.
//   PC unit : PcAdvance=1 means PC steps by 4 at this edge. Flush=1 means PC
//             loads a branch target at this edge.
interface fetch_if #(
  parameter int ADDR_W = fetch_pkg::ADDR_W_DEF
);
  logic [31:0]       PC;
  logic              Flush;
  logic              PcAdvance;
  logic              ImReq;
  logic [ADDR_W-1:0] ImAddr;
  logic              ImAck;
  logic [31:0]       ImData;
  logic              IrValid;
  logic              IrReady;
  logic [31:0]       Instr;
  logic [31:0]       IrPC;
  logic              IrErr;

  modport master (
    input  PC, Flush, ImAck, ImData, IrReady,
    output PcAdvance, ImReq, ImAddr, IrValid, Instr, IrPC, IrErr
  );

  modport slave (
    output PC, Flush, ImAck, ImData, IrReady,
    input  PcAdvance, ImReq, ImAddr, IrValid, Instr, IrPC, IrErr
  );
endinterface

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO holding fetched words on their way to decode.
// Clear wins over push/pop. A push is accepted when full only if a pop
// happens in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_data,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_head,
  output logic               o_full,
  output logic               o_empty,
  output logic [1:0]         o_count
);

  logic [ENTRY_W-1:0] r_mem [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  // Pointer, occupancy and storage update.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: translates PC to a word address, runs one memory
// request at a time, buffers up to two results for decode and discards
// wrong-path data after a flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W  = ADDR_W_DEF,
  parameter logic [31:0] IM_BASE = IM_BASE_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  fetch_if.master    bus,
  output state_t     o_dbg_state,
  output logic [1:0] o_dbg_count
);

  state_t            r_state;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;

  logic [31:0]       w_off;
  logic              w_pc_ok;
  logic [ADDR_W-1:0] w_addr;
  logic              w_ack;
  logic              w_issue;
  logic              w_push;
  entry_t            w_push_ent;
  entry_t            w_head;
  logic              w_full;
  logic              w_empty;
  logic [1:0]        w_count;

  // IM_BASE is word aligned, so alignment of the offset equals alignment of PC.
  assign w_off   = bus.PC - IM_BASE;
  assign w_pc_ok = (w_off[1:0] == 2'b00) && (bus.PC >= IM_BASE) &&
                   (w_off[31:ADDR_W+2] == '0);
  assign w_addr  = w_off[ADDR_W+1:2];

  // An ack only counts while a request is actually on the bus.
  assign w_ack = bus.ImAck && r_req;

  // Decide this cycle's issue and push; Flush and Reset suppress both.
  always_comb begin
    w_issue    = 1'b0;
    w_push     = 1'b0;
    w_push_ent = '0;
    if (!Reset && !bus.Flush) begin
      case (r_state)
        IDLE: begin
          if (!w_full) begin
            if (w_pc_ok) begin
              w_issue = 1'b1;
            end else begin
              w_push     = 1'b1;
              w_push_ent = '{instr: NOP, pc: bus.PC, err: 1'b1};
            end
          end
        end
        WAIT: begin
          if (w_ack) begin
            w_push     = 1'b1;
            w_push_ent = '{instr: bus.ImData, pc: bus.PC, err: 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // Request FSM with registered ImReq/ImAddr.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_req   <= 1'b1;
            r_addr  <= w_addr;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (w_ack) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end else if (bus.Flush) begin
            r_state <= DROP;
          end
        end
        DROP: begin
          if (w_ack) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  fetch_fifo u_fifo (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_clear (bus.Flush),
    .i_push  (w_push),
    .i_data  (w_push_ent),
    .i_pop   (bus.IrReady),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.ImReq     = r_req;
  assign bus.ImAddr    = r_addr;
  assign bus.PcAdvance = w_push;
  assign bus.IrValid   = !w_empty;
  assign bus.Instr     = w_empty ? NOP   : w_head.instr;
  assign bus.IrPC      = w_empty ? 32'h0 : w_head.pc;
  assign bus.IrErr     = w_empty ? 1'b0  : w_head.err;

  assign o_dbg_state = r_state;
  assign o_dbg_count = w_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic, all
// checked cycle by cycle against a queue-based model of the fetch stage.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_3000;

  logic       clk;
  logic       rst;
  state_t     dbg_state;
  logic [1:0] dbg_count;

  fetch_if #(.ADDR_W(10)) bus ();

  fetch_unit dut (
    .Clk         (clk),
    .Reset       (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_count (dbg_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // environment knobs and models
  logic [31:0] mem [1024];
  logic [31:0] pc;
  bit          g_rst, g_flush, g_ready, g_stray;
  logic [31:0] g_target;
  int          g_lat, cur_lat, wait_cnt;

  // fetch-stage reference: buffered entries plus the one request in flight
  logic [64:0] exp_q[$];
  bit          m_req, m_drop;
  logic [9:0]  m_addr;

  int n_checks, n_pass, n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic bit pc_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a >= BASE) && (a < BASE + 4 * 1024);
  endfunction

  function automatic int pick_lat();
    return (g_lat < 0) ? int'($urandom_range(0, 3)) : g_lat;
  endfunction

  // Compare DUT outputs with the model, then advance model and PC unit.
  task automatic model_step();
    logic [64:0] head;
    logic [64:0] ent;
    bit valid, issue, push, ack;
    valid = exp_q.size() > 0;
    head  = valid ? exp_q[0] : 65'h0;
    ack   = m_req && bus.ImAck;
    issue = 0; push = 0; ent = '0;
    if (!rst && !bus.Flush) begin
      if (!m_req && exp_q.size() < 2) begin
        if (pc_ok(pc)) issue = 1;
        else begin push = 1; ent = {32'h0, pc, 1'b1}; end
      end else if (m_req && ack && !m_drop) begin
        push = 1; ent = {mem[m_addr], pc, 1'b0};
      end
    end
    chk("ImReq", bus.ImReq, m_req);
    if (m_req) chk("ImAddr", bus.ImAddr, m_addr);
    chk("PcAdvance", bus.PcAdvance, push);
    chk("IrValid", bus.IrValid, valid);
    chk("Instr", bus.Instr, head[64:33]);
    chk("IrPC", bus.IrPC, head[32:1]);
    chk("IrErr", bus.IrErr, head[0]);
    chk("count", dbg_count, 64'(exp_q.size()));
    chk("busy", dbg_state != IDLE, m_req);
    if (rst) begin
      exp_q.delete(); m_req = 0; m_drop = 0; m_addr = '0;
    end else begin
      if (bus.Flush) exp_q.delete();
      else begin
        if (bus.IrReady && valid) void'(exp_q.pop_front());
        if (push) exp_q.push_back(ent);
      end
      if (!m_req) begin
        if (issue) begin m_req = 1; m_drop = 0; m_addr = 10'((pc - BASE) >> 2); end
      end else if (ack) begin
        m_req = 0; m_drop = 0;
      end else if (bus.Flush) begin
        m_drop = 1;
      end
    end
    if (rst) pc = BASE;
    else if (bus.Flush) pc = g_target;
    else if (push) pc = pc + 32'd4;
  endtask

  // driver: apply one cycle of inputs, check, then step to the next cycle
  task automatic tick();
    rst           = g_rst;
    bus.Flush     = g_flush;
    bus.PC        = pc;
    bus.IrReady   = g_ready;
    bus.ImAck     = (bus.ImReq && (wait_cnt >= cur_lat)) ||
                    (g_stray && !bus.ImReq && ($urandom_range(0, 3) == 0));
    bus.ImData    = mem[bus.ImAddr];
    #1;
    model_step();
    if (rst) begin wait_cnt = 0; cur_lat = pick_lat(); end
    else if (bus.ImReq && bus.ImAck) begin wait_cnt = 0; cur_lat = pick_lat(); end
    else if (bus.ImReq) wait_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && bus.ImReq; i++) tick();
    chk("idle_timeout", bus.ImReq, 0);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 40 && !bus.ImReq; i++) tick();
    chk("req_timeout", bus.ImReq, 1);
  endtask

  logic [31:0] tgt_tab [8];

  initial begin
    tgt_tab = '{32'h3000, 32'h3FFC, 32'h4000, 32'h2FFC,
                32'h3002, 32'h3041, 32'h3FF8, 32'h3100};
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    n_checks = 0; n_pass = 0; n_fail = 0;
    rst = 1; pc = BASE;
    bus.PC = pc; bus.Flush = 0; bus.ImAck = 0; bus.ImData = '0; bus.IrReady = 0;
    g_rst = 0; g_flush = 0; g_ready = 1; g_stray = 0; g_target = BASE;
    g_lat = 0; cur_lat = 0; wait_cnt = 0;
    exp_q.delete(); m_req = 0; m_drop = 0; m_addr = '0;
    repeat (3) @(posedge clk);
    #1;

    // reset values
    chk("rst_ImReq", bus.ImReq, 0);
    chk("rst_ImAddr", bus.ImAddr, 0);
    chk("rst_PcAdvance", bus.PcAdvance, 0);
    chk("rst_IrValid", bus.IrValid, 0);
    chk("rst_Instr", bus.Instr, 0);
    chk("rst_IrPC", bus.IrPC, 0);
    chk("rst_IrErr", bus.IrErr, 0);

    // zero-wait streaming from 0x3000
    tick();
    chk("first_req", bus.ImReq, 1);
    chk("first_addr", bus.ImAddr, 0);
    tick();
    chk("first_valid", bus.IrValid, 1);
    chk("first_instr", bus.Instr, mem[0]);
    chk("first_pc", bus.IrPC, BASE);
    repeat (12) tick();

    // decode stalled: two words buffer up, then popped in order
    wait_idle();
    g_flush = 1; g_target = BASE; g_ready = 0;
    tick();
    g_flush = 0;
    repeat (10) tick();
    chk("stall_count", dbg_count, 2);
    chk("stall_req", bus.ImReq, 0);
    chk("stall_head_pc", bus.IrPC, BASE);
    chk("stall_head_instr", bus.Instr, mem[0]);
    g_ready = 1;
    tick();
    chk("stall_pop2_pc", bus.IrPC, BASE + 32'd4);
    chk("stall_pop2_instr", bus.Instr, mem[1]);
    repeat (4) tick();

    // slow memory, flush in the first WAIT cycle, redirect to 0x3040
    g_lat = 3;
    wait_idle();
    cur_lat = 3;
    wait_req();
    g_flush = 1; g_target = 32'h3040;
    tick();
    g_flush = 0;
    for (int i = 0; i < 40 && bus.ImReq; i++) begin
      chk("drop_no_valid", bus.IrValid, 0);
      tick();
    end
    wait_req();
    chk("redirect_addr", bus.ImAddr, 10'h10);
    repeat (6) tick();

    // flush coinciding with an ack while one word is buffered
    g_lat = 0;
    wait_idle();
    cur_lat = 0;
    g_flush = 1; g_target = 32'h3100; g_ready = 0;
    tick();
    g_flush = 0;
    for (int i = 0; i < 20 && !(bus.IrValid && bus.ImReq); i++) tick();
    chk("pre_flush_valid", bus.IrValid, 1);
    g_flush = 1; g_target = 32'h3200;
    tick();
    g_flush = 0;
    chk("flush_ack_valid", bus.IrValid, 0);
    g_ready = 1;
    repeat (6) tick();

    // misaligned and below-base PCs produce fault entries
    wait_idle();
    g_flush = 1; g_target = 32'h3002;
    tick();
    g_flush = 0;
    tick();
    chk("fault1_valid", bus.IrValid, 1);
    chk("fault1_err", bus.IrErr, 1);
    chk("fault1_instr", bus.Instr, 0);
    chk("fault1_pc", bus.IrPC, 32'h3002);
    g_flush = 1; g_target = 32'h2FFC;
    tick();
    g_flush = 0;
    tick();
    chk("fault2_err", bus.IrErr, 1);
    chk("fault2_pc", bus.IrPC, 32'h2FFC);
    repeat (4) tick();

    // reset in the middle of a slow request, with stray acks afterwards
    g_flush = 1; g_target = BASE;
    tick();
    g_flush = 0;
    g_lat = 5;
    wait_idle();
    cur_lat = 5;
    wait_req();
    repeat (2) tick();
    g_rst = 1; g_stray = 1;
    tick();
    g_rst = 0;
    chk("midrst_ImReq", bus.ImReq, 0);
    chk("midrst_IrValid", bus.IrValid, 0);
    chk("midrst_Instr", bus.Instr, 0);
    chk("midrst_IrPC", bus.IrPC, 0);
    chk("midrst_IrErr", bus.IrErr, 0);
    repeat (8) tick();

    // random traffic
    g_lat = -1;
    for (int c = 0; c < 3000; c++) begin
      g_ready = ($urandom_range(0, 3) != 0);
      g_flush = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) g_target = tgt_tab[$urandom_range(0, 7)];
      else g_target = BASE + ($urandom_range(0, 1023) << 2);
      g_rst = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
